spi_slave: RTL
==============

# spi_slave

Companion SPI slave for the `spi_controller`/`top_spi_master` path: it receives frames from an external or on-chip SPI master and returns response data. All four SPI modes are supported, with per-frame MSB/LSB ordering and back-to-back words within one chip-select assertion. The block is fully synchronous to the system clock: `sclk`, `cs_n` and `mosi` are treated as asynchronous pins and are oversampled. It sits on the peripheral side of the SoC bus and presents a simple word-level TX/RX handshake to local logic.

## Interface
- NBITS, 8, bits per SPI word

- clk  input  1  system clock; must run at ≥ 8× the `sclk` frequency
- reset  input  1  asynchronous, active-low reset
- sclk  input  1  SPI serial clock from the master (asynchronous)
- cs_n  input  1  active-low chip select from the master (asynchronous)
- mosi  input  1  serial data from the master (asynchronous)
- miso  output  1  serial data to the master
- miso_oe  output  1  output enable for the `miso` pad driver; high only while selected
- cpol  input  1  clock polarity; latched at frame start
- cpha  input  1  clock phase; latched at frame start
- lsb_first  input  1  0 = MSB first, 1 = LSB first; latched at frame start
- tx_data  input  NBITS  next response word
- tx_load  input  1  one-cycle write strobe; captures `tx_data` into the holding buffer
- tx_ready  output  1  holding buffer empty; asserted when the buffer has been consumed by the shifter
- rx_data  output  NBITS  last fully received word; holds its value until the next word completes
- rx_valid  output  1  one-cycle pulse when `rx_data` updates
- tx_underrun  output  1  one-cycle pulse when the shifter loads while the buffer is empty (the stale buffer contents are re-sent)
- busy  output  1  high while in ACTIVE

## Operation
- **Synchronizers**
  - `sclk`, `cs_n` and `mosi` each pass through a 2-FF synchronizer, followed by one history register.
  - Edges are detected as synced ≠ history.
  - Reset values: sclk sync = 0, cs_n sync = 1, mosi sync = 0.
- **Edge definitions** (using latched cpol)
  - Leading edge = the sclk transition away from cpol.
  - Trailing edge = the transition back to cpol.
  - cpha = 0: sample on leading edge, shift on trailing edge.
  - cpha = 1: shift on leading edge, sample on trailing edge.
- **FSM: IDLE**
  - `miso_oe` = 0 and `busy` = 0; all sclk edges are ignored.
  - On a synced `cs_n` falling edge:
    - latch cpol, cpha and lsb_first;
    - clear the bit counter;
    - go to ACTIVE.
  - If cpha = 0, the shifter loads from the holding buffer in the same cycle. If cpha = 1, set `load_pending`.
- **FSM: ACTIVE**
  - `miso_oe` = 1.
  - `miso` = shifter[NBITS-1] when MSB-first, shifter[0] when LSB-first.
  - **Shift edge:**
    - If `load_pending`, load the shifter from the buffer and clear `load_pending`.
    - Otherwise shift toward the output end by one bit (left when MSB-first, right when LSB-first).
  - **Sample edge:**
    - Shift synced `mosi` into the RX shifter: into bit 0 shifting left when MSB-first, into bit NBITS-1 shifting right when LSB-first.
    - Increment the bit counter.
  - **Word completion** (sample edge with counter = NBITS-1):
    - `rx_data` ← completed word and `rx_valid` pulses;
    - counter wraps to 0;
    - `load_pending` is set so the next shift edge starts the following word.
  - A synced `cs_n` rising edge returns the FSM to IDLE from any bit position. A partial word is discarded: no `rx_valid`, `rx_data` unchanged, and `load_pending` is cleared.
- **Holding buffer**
  - `tx_load` writes the buffer and clears `tx_ready`.
  - A shifter load sets `tx_ready`. A shifter load while `tx_ready` = 1 also pulses `tx_underrun`.
  - If `tx_load` and a shifter load happen in the same cycle: the shifter takes the old buffer contents, the buffer takes the new `tx_data`, `tx_ready` = 0, and no underrun is flagged.
  - `tx_load` while `tx_ready` = 0 overwrites the buffer silently.
- **Mode inputs:** cpol, cpha and lsb_first changes during ACTIVE have no effect until the next frame.

## Timing
- **Reset values:** `miso` 0, `miso_oe` 0, `rx_data` 0, `rx_valid` 0, `tx_ready` 1, `tx_underrun` 0, `busy` 0. The holding buffer, both shifters and the counter are 0, and the FSM is in IDLE.
- **Pin-to-detect latency:** 3 `clk` cycles from a pin edge to edge detection.
  - `miso` updates 4 `clk` after the shift-edge pin transition.
  - `rx_valid` rises 4 `clk` after the final sample-edge pin transition.
- **Master constraints:**
  - with cpha = 0, the first sclk edge follows the `cs_n` fall by ≥ 4 `clk` plus the master's setup requirement;
  - each sclk half-period is ≥ 4 `clk`;
  - `cs_n` high time is ≥ 4 `clk`.
- **Back-to-back words:** no gap is required between words. `tx_data` must be loaded before the shift edge that starts the word (the first leading edge when cpha = 1, the final trailing edge of the previous word when cpha = 0).
- **Reset assertion mid-frame:** immediate return to the reset values; the remainder of the frame is ignored until a new `cs_n` fall is seen.

## Test plan
- **Mode 0, MSB-first:** `tx_load` 0xA5, master sends 0x3C → `miso` bits 1,0,1,0,0,1,0,1 and `rx_data` = 0x3C with a single `rx_valid` pulse. `tx_ready` rises at frame start.
- **All four cpol/cpha modes × lsb_first:** slave tx 0x81, master tx 0x6E → master receives 0x81 and `rx_data` = 0x6E in every combination.
- **Two back-to-back words under one `cs_n`:** tx 0x12 then 0x34 (second `tx_load` issued after the first `tx_ready` rise), rx 0xF0, 0x0F → two `rx_valid` pulses, and the master reads 0x12 then 0x34 with no `tx_underrun`.
- **Underrun:** second word not loaded → `tx_underrun` pulses once and 0x12 is re-sent.
- **Abort:** `cs_n` raised after 5 bits → no `rx_valid`, `rx_data` holds its prior value, `miso_oe` falls 3 `clk` later. The next full frame receives 0x55 correctly.
- **Reset and concurrent events:** `reset` low mid-word → all outputs return to their reset values. A `tx_load` of 0x99 in the same cycle as a shifter load → the shifter sends the old buffer, the next word sends 0x99, and `tx_ready` = 0.

Source files
------------

// File: rtl/spi_slave.sv
// SPI slave with oversampled pins, all four cpol/cpha modes, per-frame bit order
// and a single-word TX holding buffer with a word-level RX/TX handshake.
module spi_slave #(
   parameter int NBITS = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sclk,
   input  logic             cs_n,
   input  logic             mosi,
   output logic             miso,
   output logic             miso_oe,
   input  logic             cpol,
   input  logic             cpha,
   input  logic             lsb_first,
   input  logic [NBITS-1:0] tx_data,
   input  logic             tx_load,
   output logic             tx_ready,
   output logic [NBITS-1:0] rx_data,
   output logic             rx_valid,
   output logic             tx_underrun,
   output logic             busy
);

   localparam int CNT_W = (NBITS > 1) ? $clog2(NBITS) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NBITS - 1);

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t state_q, state_d;

   logic sclk_m, sclk_s, sclk_h;
   logic cs_m, cs_s, cs_h;
   logic mosi_m, mosi_s;

   logic cpol_q, cpha_q, lsb_q;
   logic load_pending;
   logic word_done;
   logic [CNT_W-1:0] bit_cnt;
   logic [NBITS-1:0] tx_shift, rx_shift, tx_buf;

   logic sclk_edge, leading_edge, trailing_edge, shift_edge, sample_edge;
   logic cs_fall, cs_rise;
   logic start_frame, load_now, shift_now, sample_now, last_sample;
   logic out_bit;

   // NOTE: every clocked block uses non-blocking assignments so all registers
   // update from the same pre-edge values and the synchronizer chain shifts correctly.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sclk_m <= 1'b0;
         sclk_s <= 1'b0;
         sclk_h <= 1'b0;
         cs_m   <= 1'b1;
         cs_s   <= 1'b1;
         cs_h   <= 1'b1;
         mosi_m <= 1'b0;
         mosi_s <= 1'b0;
      end else begin
         sclk_m <= sclk;
         sclk_s <= sclk_m;
         sclk_h <= sclk_s;
         cs_m   <= cs_n;
         cs_s   <= cs_m;
         cs_h   <= cs_s;
         mosi_m <= mosi;
         mosi_s <= mosi_m;
      end
   end

   // Leading edge moves sclk away from the idle level latched at frame start.
   assign sclk_edge     = sclk_s ^ sclk_h;
   assign leading_edge  = sclk_edge && (sclk_s != cpol_q);
   assign trailing_edge = sclk_edge && (sclk_s == cpol_q);
   assign shift_edge    = cpha_q ? leading_edge  : trailing_edge;
   assign sample_edge   = cpha_q ? trailing_edge : leading_edge;
   assign cs_fall       = cs_h & ~cs_s;
   assign cs_rise       = ~cs_h & cs_s;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // NOTE: every output of this block gets a default first, so no path
   // through the case leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_d     = state_q;
      start_frame = 1'b0;
      load_now    = 1'b0;
      shift_now   = 1'b0;
      sample_now  = 1'b0;
      case (state_q)
         IDLE: begin
            if (cs_fall) begin
               state_d     = ACTIVE;
               start_frame = 1'b1;
               load_now    = ~cpha;
            end
         end
         ACTIVE: begin
            if (cs_rise) begin
               state_d = IDLE;
            end else begin
               if (shift_edge) begin
                  if (load_pending) load_now  = 1'b1;
                  else              shift_now = 1'b1;
               end
               sample_now = sample_edge;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign last_sample = sample_now && (bit_cnt == LAST_BIT);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cpol_q       <= 1'b0;
         cpha_q       <= 1'b0;
         lsb_q        <= 1'b0;
         bit_cnt      <= '0;
         load_pending <= 1'b0;
      end else begin
         if (start_frame) begin
            cpol_q <= cpol;
            cpha_q <= cpha;
            lsb_q  <= lsb_first;
         end

         if (start_frame || last_sample) bit_cnt <= '0;
         else if (sample_now)            bit_cnt <= bit_cnt + 1'b1;

         // A word boundary arms a reload; leaving the frame drops it.
         if (start_frame)          load_pending <= cpha;
         else if (state_d == IDLE) load_pending <= 1'b0;
         else if (last_sample)     load_pending <= 1'b1;
         else if (load_now)        load_pending <= 1'b0;
      end
   end

   // Holding buffer: a same-cycle tx_load wins over the shifter consuming it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_buf      <= '0;
         tx_ready    <= 1'b1;
         tx_underrun <= 1'b0;
         tx_shift    <= '0;
      end else begin
         if (tx_load) begin
            tx_buf   <= tx_data;
            tx_ready <= 1'b0;
         end else if (load_now) begin
            tx_ready <= 1'b1;
         end
         tx_underrun <= load_now && tx_ready && !tx_load;

         if (load_now)       tx_shift <= tx_buf;
         else if (shift_now) tx_shift <= lsb_q ? {1'b0, tx_shift[NBITS-1:1]}
                                               : {tx_shift[NBITS-2:0], 1'b0};
      end
   end

   assign out_bit = lsb_q ? tx_shift[0] : tx_shift[NBITS-1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_shift  <= '0;
         word_done <= 1'b0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         miso      <= 1'b0;
      end else begin
         if (sample_now) rx_shift <= lsb_q ? {mosi_s, rx_shift[NBITS-1:1]}
                                           : {rx_shift[NBITS-2:0], mosi_s};
         word_done <= last_sample;
         rx_valid  <= word_done;
         if (word_done) rx_data <= rx_shift;
         miso <= (state_q == ACTIVE) ? out_bit : 1'b0;
      end
   end

   assign miso_oe = (state_q == ACTIVE);
   assign busy    = (state_q == ACTIVE);

endmodule
